// File: rtl/jhash_pkg.sv
// Shared definitions for the hash output path: defaults, FSM encoding and queue entry layout.
package jhash_pkg;

    localparam logic [31:0] PAD_WORD_DEF  = 32'h0000_0000;
    localparam logic [31:0] TRL_MAGIC_DEF = 32'h4A48_5348;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FL_PAD = 2'd1,
        FL_TRL = 2'd2
    } jhash_state_t;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } q_entry_t;

endpackage

// File: rtl/jhash_out_q.sv
// Small synchronous FIFO of 65-bit queue entries; DEPTH must be a power of two, at least 2.
module jhash_out_q
    import jhash_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  q_entry_t push_ent,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output q_entry_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    q_entry_t       mem [DEPTH];
    logic [AW:0]    wptr_q, rptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= push_ent;
    end

endmodule

// File: rtl/jhash_out.sv
// Packs 32-bit hashes into 64-bit words, queues them and writes them to the destination FIFO.
// Optional trailer word per flush is enabled with `define JHASH_OUT_TRAILER_EN.
module jhash_out
    import jhash_pkg::*;
#(
    parameter int unsigned QDEPTH    = 4,
`ifdef JHASH_OUT_TRAILER_EN
    parameter logic [31:0] TRL_MAGIC = TRL_MAGIC_DEF,
`endif
    parameter logic [31:0] PAD_WORD  = PAD_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] hash_out,
    input  logic        hash_done,
    input  logic        flush,
    input  logic        fo_full,
    output logic [63:0] fo,
    output logic        m_dst_putn,
    output logic        m_dst_last,
    output logic        flush_busy,
    output logic        q_ovf
);

    jhash_state_t state_q, state_d;
    logic         half_v_q, half_v_d;
    logic [31:0]  half_lo_q, half_lo_d;
    logic         pend_v_q, pend_v_d;
    logic [31:0]  pend_data_q, pend_data_d;
`ifdef JHASH_OUT_TRAILER_EN
    logic [31:0]  cnt_q, cnt_d;
`endif
    logic         ovf_set, enq, push, pop, q_full, q_empty;
    q_entry_t     enq_ent, head;

    always_comb begin
        state_d     = state_q;
        half_v_d    = half_v_q;
        half_lo_d   = half_lo_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
`ifdef JHASH_OUT_TRAILER_EN
        cnt_d       = cnt_q;
`endif
        ovf_set     = 1'b0;
        enq         = 1'b0;
        enq_ent     = '0;
        case (state_q)
            ACCUM: begin
                // A held hash goes in ahead of a fresh one; two hashes never make two words.
                if (pend_v_q) begin
                    pend_v_d = 1'b0;
                    if (half_v_d) begin
                        enq          = 1'b1;
                        enq_ent.data = {pend_data_q, half_lo_d};
                        half_v_d     = 1'b0;
                    end else begin
                        half_lo_d = pend_data_q;
                        half_v_d  = 1'b1;
                    end
`ifdef JHASH_OUT_TRAILER_EN
                    cnt_d = cnt_d + 32'd1;
`endif
                end
                if (hash_done) begin
                    if (half_v_d) begin
                        enq          = 1'b1;
                        enq_ent.data = {hash_out, half_lo_d};
                        half_v_d     = 1'b0;
                    end else begin
                        half_lo_d = hash_out;
                        half_v_d  = 1'b1;
                    end
`ifdef JHASH_OUT_TRAILER_EN
                    cnt_d = cnt_d + 32'd1;
`endif
                end
                if (flush) begin
`ifdef JHASH_OUT_TRAILER_EN
                    state_d = half_v_d ? FL_PAD : FL_TRL;
`else
                    if (half_v_d) begin
                        state_d = FL_PAD;
                    end else if (enq) begin
                        enq_ent.last = 1'b1;
                    end else begin
                        enq     = 1'b1;
                        enq_ent = '{last: 1'b1, data: {PAD_WORD, PAD_WORD}};
                    end
`endif
                end
            end
            FL_PAD: begin
                enq          = 1'b1;
                enq_ent.data = {PAD_WORD, half_lo_q};
                half_v_d     = 1'b0;
`ifdef JHASH_OUT_TRAILER_EN
                state_d      = FL_TRL;
`else
                enq_ent.last = 1'b1;
                state_d      = ACCUM;
`endif
            end
`ifdef JHASH_OUT_TRAILER_EN
            FL_TRL: begin
                enq     = 1'b1;
                enq_ent = '{last: 1'b1, data: {TRL_MAGIC, cnt_q}};
                cnt_d   = '0;
                state_d = ACCUM;
            end
`endif
            default: state_d = ACCUM;
        endcase
        // Hashes arriving mid-flush belong to the next job and wait in the pending slot.
        if (state_q != ACCUM && hash_done) begin
            if (pend_v_q) begin
                ovf_set = 1'b1;
            end else begin
                pend_v_d    = 1'b1;
                pend_data_d = hash_out;
            end
        end
    end

    assign pop        = ce && !fo_full && !q_empty;
    assign push       = enq && (!q_full || pop);
    assign flush_busy = (state_q != ACCUM);

    jhash_out_q #(
        .DEPTH (QDEPTH)
    ) u_q (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_ent (enq_ent),
        .pop      (pop),
        .full     (q_full),
        .empty    (q_empty),
        .head     (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            half_v_q    <= 1'b0;
            half_lo_q   <= '0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
`ifdef JHASH_OUT_TRAILER_EN
            cnt_q       <= '0;
`endif
            q_ovf       <= 1'b0;
            fo          <= '0;
            m_dst_putn  <= 1'b1;
            m_dst_last  <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_v_q    <= half_v_d;
            half_lo_q   <= half_lo_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
`ifdef JHASH_OUT_TRAILER_EN
            cnt_q       <= cnt_d;
`endif
            q_ovf       <= q_ovf | ovf_set | (enq && !push);
            m_dst_putn  <= !pop;
            if (pop) begin
                fo         <= head.data;
                m_dst_last <= head.last;
            end
        end
    end

endmodule

// File: tb/tb_jhash_out.sv
// Directed bench for jhash_out; expectations cover both trailer-enabled and trailer-less builds.
module tb_jhash_out;

`ifdef JHASH_OUT_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, hash_done, flush, fo_full;
    logic [31:0] hash_out;
    logic [63:0] fo;
    logic        m_dst_putn, m_dst_last, flush_busy, q_ovf;

    int n_cmp = 0;
    int n_fail = 0;

    jhash_out dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .hash_out   (hash_out),
        .hash_done  (hash_done),
        .flush      (flush),
        .fo_full    (fo_full),
        .fo         (fo),
        .m_dst_putn (m_dst_putn),
        .m_dst_last (m_dst_last),
        .flush_busy (flush_busy),
        .q_ovf      (q_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          done;
        logic [31:0] h;
        bit          fl;
        bit          e_putn;
        logic [63:0] e_fo;
        bit          e_last;
        bit          e_fb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input bit d, input logic [31:0] h, input bit fl);
        hash_done = d;
        hash_out  = h;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;
        chk("rst_fo", 0, fo, 64'h0);
        chk("rst_putn", 0, 64'(m_dst_putn), 64'h1);
        chk("rst_last", 0, 64'(m_dst_last), 64'h0);
        chk("rst_fb", 0, 64'(flush_busy), 64'h0);
        chk("rst_ovf", 0, 64'(q_ovf), 64'h0);
    endtask

    // Each row: stimulus, then expected outputs for trailer-less and trailer builds.
    task automatic add(input bit d, input logic [31:0] h, input bit fl,
                       input bit np, input logic [63:0] nfo, input bit nl, input bit nfb,
                       input bit tp, input logic [63:0] tfo, input bit tl, input bit tfb);
        vec_t v;
        v.done = d;
        v.h    = h;
        v.fl   = fl;
        v.e_putn = TRL ? tp : np;
        v.e_fo   = TRL ? tfo : nfo;
        v.e_last = TRL ? tl : nl;
        v.e_fb   = TRL ? tfb : nfb;
        vecs.push_back(v);
    endtask

    localparam logic [63:0] W1  = 64'h22222222_11111111;
    localparam logic [63:0] W2  = 64'h44444444_33333333;
    localparam logic [63:0] WAB = 64'h0000000B_0000000A;
    localparam logic [63:0] WC  = 64'h00000000_0000000C;
    localparam logic [63:0] WDC = 64'h0000000D_0000000C;
    localparam logic [63:0] W01 = 64'h00000000_00000001;
    localparam logic [63:0] W02 = 64'h00000000_00000002;
    localparam logic [63:0] T4  = 64'h4A485348_00000004;
    localparam logic [63:0] T3  = 64'h4A485348_00000003;
    localparam logic [63:0] T2  = 64'h4A485348_00000002;
    localparam logic [63:0] T1  = 64'h4A485348_00000001;
    localparam logic [63:0] T0  = 64'h4A485348_00000000;

    initial begin
        logic [63:0] exp_w [4];
        int nw;

        // Four-hash job
        add(1, 32'h11111111, 0,  1, 0,   0, 0,  1, 0,   0, 0);
        add(1, 32'h22222222, 0,  1, 0,   0, 0,  1, 0,   0, 0);
        add(1, 32'h33333333, 0,  0, W1,  0, 0,  0, W1,  0, 0);
        add(1, 32'h44444444, 0,  1, W1,  0, 0,  1, W1,  0, 0);
        add(0, 0,            1,  0, W2,  0, 0,  0, W2,  0, 1);
        add(0, 0,            0,  0, 0,   1, 0,  1, W2,  0, 0);
        add(0, 0,            0,  1, 0,   1, 0,  0, T4,  1, 0);
        add(0, 0,            0,  1, 0,   1, 0,  1, T4,  1, 0);
        // Three-hash job, padded
        add(1, 32'hA,        0,  1, 0,   1, 0,  1, T4,  1, 0);
        add(1, 32'hB,        0,  1, 0,   1, 0,  1, T4,  1, 0);
        add(1, 32'hC,        0,  0, WAB, 0, 0,  0, WAB, 0, 0);
        add(0, 0,            1,  1, WAB, 0, 1,  1, WAB, 0, 1);
        add(0, 0,            0,  1, WAB, 0, 0,  1, WAB, 0, 1);
        add(0, 0,            0,  0, WC,  1, 0,  0, WC,  0, 0);
        add(0, 0,            0,  1, WC,  1, 0,  0, T3,  1, 0);
        add(0, 0,            0,  1, WC,  1, 0,  1, T3,  1, 0);
        // Hash and flush in the same cycle completing a word
        add(1, 32'hC,        0,  1, WC,  1, 0,  1, T3,  1, 0);
        add(1, 32'hD,        1,  1, WC,  1, 0,  1, T3,  1, 1);
        add(0, 0,            0,  0, WDC, 1, 0,  0, WDC, 0, 0);
        add(0, 0,            0,  1, WDC, 1, 0,  0, T2,  1, 0);
        add(0, 0,            0,  1, WDC, 1, 0,  1, T2,  1, 0);
        // Hash during FL_PAD belongs to the next job
        add(1, 32'h1,        0,  1, WDC, 1, 0,  1, T2,  1, 0);
        add(0, 0,            1,  1, WDC, 1, 1,  1, T2,  1, 1);
        add(1, 32'h2,        0,  1, WDC, 1, 0,  1, T2,  1, 1);
        add(0, 0,            0,  0, W01, 1, 0,  0, W01, 0, 0);
        add(0, 0,            0,  1, W01, 1, 0,  0, T1,  1, 0);
        add(0, 0,            1,  1, W01, 1, 1,  1, T1,  1, 1);
        add(0, 0,            0,  1, W01, 1, 0,  1, T1,  1, 1);
        add(0, 0,            0,  0, W02, 1, 0,  0, W02, 0, 0);
        add(0, 0,            0,  1, W02, 1, 0,  0, T1,  1, 0);
        add(0, 0,            0,  1, W02, 1, 0,  1, T1,  1, 0);
        // Empty job
        add(0, 0,            1,  1, W02, 1, 0,  1, T1,  1, 1);
        add(0, 0,            0,  0, 0,   1, 0,  1, T1,  1, 0);
        add(0, 0,            0,  1, 0,   1, 0,  0, T0,  1, 0);

        ce = 1'b1;
        fo_full = 1'b0;
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].done, vecs[i].h, vecs[i].fl);
            chk("vec_putn", i, 64'(m_dst_putn), 64'(vecs[i].e_putn));
            chk("vec_fo", i, fo, vecs[i].e_fo);
            chk("vec_last", i, 64'(m_dst_last), 64'(vecs[i].e_last));
            chk("vec_busy", i, 64'(flush_busy), 64'(vecs[i].e_fb));
            chk("vec_ovf", i, 64'(q_ovf), 64'h0);
        end

        // Overflow: 12 hashes with the FIFO blocked fill 4 slots, the 5th word is dropped
        do_reset();
        fo_full = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1, 32'(i), 0);
            chk("ovf_flag", i, 64'(q_ovf), (i >= 10) ? 64'h1 : 64'h0);
        end
        fo_full = 1'b0;
        exp_w[0] = 64'h00000002_00000001;
        exp_w[1] = 64'h00000004_00000003;
        exp_w[2] = 64'h00000006_00000005;
        exp_w[3] = 64'h00000008_00000007;
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            if (!m_dst_putn) begin
                if (nw < 4) chk("ovf_data", nw, fo, exp_w[nw]);
                nw++;
            end
        end
        chk("ovf_nwrites", 0, 64'(nw), 64'd4);
        chk("ovf_sticky", 0, 64'(q_ovf), 64'h1);

        // Reset mid-job discards queued and half-built data
        fo_full = 1'b1;
        step(1, 32'h5, 0);
        step(1, 32'h6, 0);
        step(1, 32'h7, 0);
        do_reset();
        fo_full = 1'b0;
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            if (!m_dst_putn) nw++;
        end
        chk("rst_discard", 0, 64'(nw), 64'd0);

        // ce low stalls writes while capture continues
        ce = 1'b0;
        step(1, 32'h77, 0);
        step(1, 32'h88, 0);
        step(0, 0, 0);
        chk("ce_stall", 0, 64'(m_dst_putn), 64'h1);
        ce = 1'b1;
        step(0, 0, 0);
        chk("ce_putn", 0, 64'(m_dst_putn), 64'h0);
        chk("ce_data", 0, fo, 64'h00000088_00000077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
